// File: rtl/tone_decoder_if.sv
// Tone decoder bus: the incoming tone line plus the decoded-note results.
interface tone_decoder_if #(
    parameter int unsigned CNT_W = 20
);
    logic             tone_in;
    logic [5:0]       note_idx;
    logic             note_valid;
    logic             note_strobe;
    logic [CNT_W-1:0] period;

    modport master (output tone_in, input note_idx, note_valid, note_strobe, period);
    modport slave  (input tone_in, output note_idx, note_valid, note_strobe, period);
endinterface

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone in clk cycles and identifies which
// of the 36 piano notes (C3..B5) it carries, confirming after repeated hits.
module tone_decoder #(
    parameter int unsigned M         = 50,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned TIMEOUT   = 524288,
    parameter int unsigned TOL       = 64,
    parameter int unsigned MATCH_REQ = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C       = CNT_W'(TOL);
    localparam logic [5:0]       LAST_K      = 6'd35;
    localparam logic [2:0]       RUN_MAX     = 3'd7;
    localparam logic [2:0]       MATCH_REQ_C = 3'(MATCH_REQ);

    typedef enum logic [1:0] {IDLE, MEASURE, SEARCH} state_e;

    // Expected full period of note k: 2*(M*N_k + 1) cycles.
    function automatic logic [CNT_W-1:0] exp_period(input logic [5:0] k);
        int unsigned n;
        case (k)
            6'd0:  n = 3822;  6'd1:  n = 3608;  6'd2:  n = 3405;  6'd3:  n = 3214;
            6'd4:  n = 3034;  6'd5:  n = 2864;  6'd6:  n = 2703;  6'd7:  n = 2551;
            6'd8:  n = 2408;  6'd9:  n = 2273;  6'd10: n = 2145;  6'd11: n = 2025;
            6'd12: n = 1911;  6'd13: n = 1804;  6'd14: n = 1703;  6'd15: n = 1607;
            6'd16: n = 1517;  6'd17: n = 1432;  6'd18: n = 1351;  6'd19: n = 1276;
            6'd20: n = 1204;  6'd21: n = 1136;  6'd22: n = 1073;  6'd23: n = 1012;
            6'd24: n = 956;   6'd25: n = 902;   6'd26: n = 851;   6'd27: n = 804;
            6'd28: n = 758;   6'd29: n = 716;   6'd30: n = 676;   6'd31: n = 638;
            6'd32: n = 602;   6'd33: n = 568;   6'd34: n = 536;   6'd35: n = 506;
            default: n = 0;
        endcase
        return CNT_W'(2 * (M * n + 1));
    endfunction

    logic [2:0]       sync_q;
    logic             rise_c;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] exp_c, diff_c;
    logic             hit_c;
    logic [5:0]       k_q, k_d, cand_q, cand_d, idx_q, idx_d;
    logic [2:0]       run_q, run_d, run_next;
    logic             valid_q, valid_d, strobe_q, strobe_d;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 3'b000;
        else        sync_q <= {sync_q[1:0], bus.tone_in};
    end

    assign rise_c    = sync_q[1] & ~sync_q[2];
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign exp_c     = exp_period(k_q);
    assign diff_c    = (period_q >= exp_c) ? (period_q - exp_c) : (exp_c - period_q);
    assign hit_c     = (diff_c <= TOL_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            k_q      <= '0;
            cand_q   <= '0;
            idx_q    <= '0;
            run_q    <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            k_q      <= k_d;
            cand_q   <= cand_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        k_d      = k_q;
        cand_d   = cand_q;
        idx_d    = idx_q;
        run_d    = run_q;
        run_next = run_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_c) state_d = MEASURE;
            end
            MEASURE: begin
                cnt_d = cnt_inc_c;
                if (rise_c) begin
                    period_d = cnt_inc_c;
                    cnt_d    = '0;
                    k_d      = '0;
                    state_d  = SEARCH;
                end else if (cnt_inc_c == TIMEOUT_C) begin
                    // Tone absent: fall back to waiting for a fresh first edge.
                    valid_d = 1'b0;
                    run_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                cnt_d = cnt_inc_c;
                if (rise_c) begin
                    valid_d = 1'b0;
                    run_d   = '0;
                    cnt_d   = '0;
                    state_d = MEASURE;
                end else if (hit_c) begin
                    if (k_q == cand_q) begin
                        run_next = (run_q == RUN_MAX) ? run_q : run_q + 3'd1;
                    end else begin
                        cand_d   = k_q;
                        run_next = 3'd1;
                        valid_d  = 1'b0;
                    end
                    run_d = run_next;
                    if (run_next >= MATCH_REQ_C) begin
                        valid_d = 1'b1;
                        idx_d   = k_q;
                    end
                    state_d = MEASURE;
                end else if (k_q == LAST_K) begin
                    valid_d = 1'b0;
                    run_d   = '0;
                    state_d = MEASURE;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        strobe_d = valid_d & ~valid_q;
    end

    assign bus.note_idx    = idx_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_strobe = strobe_q;
    assign bus.period      = period_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: an edge-timeline note model checked every
// cycle, plus literal expectations at the interesting points.
module tb_tone_decoder;

    localparam int unsigned M         = 1;
    localparam int unsigned CNT_W     = 14;
    localparam int unsigned TIMEOUT   = 8192;
    localparam int unsigned TOL       = 8;
    localparam int unsigned MATCH_REQ = 2;

    // Periods for M=1: 2*(N+1).
    localparam int P_A4   = 2274;
    localparam int P_B4   = 2026;
    localparam int P_C3   = 7646;
    localparam int P_B5   = 1014;
    localparam int P_TOLH = 2282;
    localparam int P_TOLM = 2283;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tone_decoder_if #(.CNT_W(CNT_W)) bus ();

    tone_decoder #(
        .M(M), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL), .MATCH_REQ(MATCH_REQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_rise = 0;

    int n_tab [36] = '{3822, 3608, 3405, 3214, 3034, 2864, 2703, 2551, 2408, 2273, 2145, 2025,
                       1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012,
                       956, 902, 851, 804, 758, 716, 676, 638, 602, 568, 536, 506};

    // Model: edge numbers at which a synchronized rising edge takes effect.
    int rise_q[$];
    bit m_active, m_pend, m_hit, m_valid, m_strobe;
    int m_last, m_apply, m_k, m_cand, m_run, m_idx, m_period;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    function automatic int find_note(input int p);
        for (int k = 0; k < 36; k++) begin
            int e = 2 * (int'(M) * n_tab[k] + 1);
            int d = (p > e) ? p - e : e - p;
            if (d <= int'(TOL)) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rise_q.delete();
        m_active = 0; m_pend = 0; m_hit = 0; m_valid = 0; m_strobe = 0;
        m_last = 0; m_apply = 0; m_k = 0; m_cand = 0; m_run = 0; m_idx = 0; m_period = 0;
    endtask

    task automatic model_nomatch();
        m_valid = 0;
        m_run = 0;
    endtask

    task automatic model_hit(input int k);
        if (k == m_cand) begin
            m_run = (m_run >= 7) ? 7 : m_run + 1;
        end else begin
            m_cand = k;
            m_run = 1;
            m_valid = 0;
        end
        if (m_run >= int'(MATCH_REQ)) begin
            m_valid = 1;
            m_idx = k;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            bit old_valid;
            bit rise;
            old_valid = m_valid;
            rise = (rise_q.size() > 0) && (rise_q[0] == cyc);
            if (rise) void'(rise_q.pop_front());
            if (rise && m_pend) begin
                m_pend = 0;
                m_last = cyc;
                model_nomatch();
            end else if (m_pend && m_apply == cyc) begin
                m_pend = 0;
                if (m_hit) model_hit(m_k);
                else model_nomatch();
            end else if (rise) begin
                if (!m_active) begin
                    m_active = 1;
                end else begin
                    m_period = cyc - m_last;
                    m_k = find_note(m_period);
                    m_hit = (m_k >= 0);
                    m_pend = 1;
                    m_apply = m_hit ? cyc + 1 + m_k : cyc + 36;
                end
                m_last = cyc;
            end else if (m_active && !m_pend && (cyc - m_last) == int'(TIMEOUT)) begin
                m_active = 0;
                model_nomatch();
            end
            m_strobe = m_valid & ~old_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("note_valid", int'(bus.note_valid), int'(m_valid));
            chk("note_idx", int'(bus.note_idx), m_idx);
            chk("note_strobe", int'(bus.note_strobe), int'(m_strobe));
            chk("period", int'(bus.period), m_period);
            if (bus.note_strobe) strobe_cnt++;
        end
    end

    // One tone cycle of length t starting now (called #1 after a posedge).
    task automatic tone_period(input int t);
        bus.tone_in = 1'b1;
        last_rise = cyc + 3;
        rise_q.push_back(cyc + 3);
        repeat (t / 2) @(posedge clk);
        #1 bus.tone_in = 1'b0;
        repeat (t - t / 2) @(posedge clk);
        #1;
    endtask

    task automatic tone_burst(input int t, input int n);
        for (int i = 0; i < n; i++) tone_period(t);
    endtask

    initial begin
        model_reset();
        bus.tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(bus.note_valid), 0);
        chk("reset_idx", int'(bus.note_idx), 0);
        chk("reset_strobe", int'(bus.note_strobe), 0);
        chk("reset_period", int'(bus.period), 0);
        rst_n = 1'b1;

        // A4 loopback
        strobe_cnt = 0;
        tone_burst(P_A4, 3);
        chk("a4_period", int'(bus.period), 2274);
        chk("a4_valid", int'(bus.note_valid), 1);
        chk("a4_idx", int'(bus.note_idx), 21);
        chk("a4_strobes", strobe_cnt, 1);

        // Extremes
        tone_burst(P_C3, 3);
        chk("c3_valid", int'(bus.note_valid), 1);
        chk("c3_idx", int'(bus.note_idx), 0);
        chk("c3_period", int'(bus.period), 7646);
        tone_burst(P_B5, 3);
        chk("b5_valid", int'(bus.note_valid), 1);
        chk("b5_idx", int'(bus.note_idx), 35);

        // Tolerance edge hit
        tone_burst(P_TOLH, 3);
        chk("tol_hit_valid", int'(bus.note_valid), 1);
        chk("tol_hit_idx", int'(bus.note_idx), 21);
        chk("tol_hit_period", int'(bus.period), 2282);

        // Note change A4 -> B4
        strobe_cnt = 0;
        tone_burst(P_B4, 2);
        chk("chg_drop_valid", int'(bus.note_valid), 0);
        chk("chg_drop_period", int'(bus.period), 2026);
        tone_period(P_B4);
        chk("chg_valid", int'(bus.note_valid), 1);
        chk("chg_idx", int'(bus.note_idx), 23);
        chk("chg_strobes", strobe_cnt, 1);

        // Just outside tolerance: no match, index held
        tone_burst(P_TOLM, 2);
        chk("tol_miss_valid", int'(bus.note_valid), 0);
        chk("tol_miss_idx", int'(bus.note_idx), 23);
        chk("tol_miss_period", int'(bus.period), 2283);

        // Re-establish A4, then let the tone stop
        tone_burst(P_A4, 3);
        chk("pre_to_valid", int'(bus.note_valid), 1);
        repeat (last_rise + int'(TIMEOUT) - 1 - cyc) @(posedge clk);
        #1;
        chk("to_minus1_valid", int'(bus.note_valid), 1);
        @(posedge clk);
        #1;
        chk("to_valid", int'(bus.note_valid), 0);

        // Single edge after timeout: no capture; second edge captures
        tone_period(P_A4);
        chk("to_edge1_period", int'(bus.period), 2274);
        tone_period(P_B4);
        chk("to_edge2_period", int'(bus.period), 2274);
        tone_period(P_A4);
        chk("to_edge3_period", int'(bus.period), 2026);
        tone_burst(P_A4, 2);
        chk("pre_rst_valid", int'(bus.note_valid), 1);

        // Asynchronous reset while comparing k=10
        bus.tone_in = 1'b1;
        rise_q.push_back(cyc + 3);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_valid", int'(bus.note_valid), 0);
        chk("rst_mid_idx", int'(bus.note_idx), 0);
        chk("rst_mid_strobe", int'(bus.note_strobe), 0);
        chk("rst_mid_period", int'(bus.period), 0);
        bus.tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Resume from IDLE
        tone_burst(P_B5, 3);
        chk("resume_valid", int'(bus.note_valid), 1);
        chk("resume_idx", int'(bus.note_idx), 35);
        chk("resume_period", int'(bus.period), 1014);

        repeat (10) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
